adex_param_streamer: RTL

//   Host-side transmitter for the AdEx neuron nibble-serial parameter-load protocol.

---
 rtl/adex_param_streamer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adex_param_streamer.sv
// Host-side transmitter for the AdEx nibble-serial parameter-load protocol.
// Sends a header, 16 parameter nibbles (MSB first) and a 0xF footer, then holds load_mode.
module adex_param_streamer #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [63:0] params_i,
  input  logic        abort_i,
  output logic        load_mode_o,
  output logic        load_enable_o,
  output logic [3:0]  nibble_out_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o
);

  localparam logic [15:0] HalfLast = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);
  localparam logic [4:0]  SymLast  = 5'd17;

  typedef enum logic [1:0] {StIdle, StSend, StHold, StFinish} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  sym_q, sym_d;
  logic        phase_q, phase_d;  // 0 = LOW phase, 1 = HIGH phase
  logic [63:0] shadow_q, shadow_d;

  logic        load_mode_q, load_mode_d;
  logic        load_enable_q, load_enable_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic [3:0]  nib_idx;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sym_q    <= '0;
      phase_q  <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StSend;
          cnt_d    = '0;
          sym_d    = '0;
          phase_d  = 1'b0;
          shadow_d = params_i;
        end
      end
      StSend: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (sym_q == SymLast) state_d = StHold;
            else                  sym_d   = sym_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StHold: begin
        if (abort_i)                state_d = StIdle;
        else if (cnt_q == HoldLast) state_d = StFinish;
        else                        cnt_d   = cnt_q + 16'd1;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered lines line up with the state.
  always_comb begin
    nib_idx       = 4'hF - (sym_d[3:0] - 4'd1);
    load_mode_d   = (state_d == StSend) || (state_d == StHold);
    load_enable_d = (state_d == StSend) && phase_d;
    nibble_d      = 4'h0;
    if (state_d == StSend) begin
      if (sym_d == 5'd0)        nibble_d = 4'h0;
      else if (sym_d == SymLast) nibble_d = 4'hF;
      else                       nibble_d = shadow_d[{nib_idx, 2'b00} +: 4];
    end
    busy_d    = load_mode_d;
    done_d    = (state_d == StFinish);
    aborted_d = abort_i && ((state_q == StSend) || (state_q == StHold));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_mode_q   <= 1'b0;
      load_enable_q <= 1'b0;
      nibble_q      <= 4'h0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      load_mode_q   <= load_mode_d;
      load_enable_q <= load_enable_d;
      nibble_q      <= nibble_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  assign load_mode_o   = load_mode_q;
  assign load_enable_o = load_enable_q;
  assign nibble_out_o  = nibble_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;

endmodule
